hex_dump_formatter: RTL and testbench

HEX_DUMP_FORMATTER -- requirements
Module: hex_dump_formatter

---
 rtl/hex_dump_formatter.sv | 126 ++++++++++++
 tb/tb_hex_dump_formatter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_dump_formatter.sv
// Hex dump formatter: turns captured frame bytes into lowercase hex text for
// uart_tx, three or four characters per byte ("hh " or "hh\r\n").
module hex_dump_formatter #(
    parameter int BYTES_PER_LINE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_d,
    input  logic       in_valid,
    input  logic       in_eof,
    output logic       in_ready,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       busy,
    output logic [1:0] dbg_state_o,
    output logic [7:0] dbg_col_o
);

    // Handshakes: a byte moves on a rising edge where in_valid && in_ready.
    // in_ready is registered from the next state, so it is low for the whole
    // emission of a byte and for the first cycle after reset. On the uart side
    // tx_dv is a one-cycle strobe issued only while tx_active is low; tx_done
    // is honoured only in WAIT.
    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        nl_q, nl_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  col_q, col_d;
    logic        in_ready_q;
    logic [7:0]  tx_byte_q;
    logic [7:0]  cur_char;
    logic [1:0]  last_idx;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Character index: 0 hi nibble, 1 lo nibble, 2 space or CR, 3 LF.
    assign last_idx = nl_q ? 2'd3 : 2'd2;

    always_comb begin
        cur_char = 8'h00;
        case (idx_q)
            2'd0:    cur_char = hex_char(data_q[7:4]);
            2'd1:    cur_char = hex_char(data_q[3:0]);
            2'd2:    cur_char = nl_q ? 8'h0D : 8'h20;
            default: cur_char = 8'h0A;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        nl_d    = nl_q;
        idx_d   = idx_q;
        col_d   = col_q;
        tx_dv   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d  = in_d;
                    nl_d    = in_eof || (col_q == LAST_COL);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d   = 2'd0;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_active) begin
                    tx_dv   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (idx_q == last_idx) begin
                        // Column bookkeeping happens once the whole byte is out.
                        col_d   = nl_q ? 8'd0 : col_q + 8'd1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx_byte follows the character during the strobe and then holds it.
    assign tx_byte = tx_dv ? cur_char : tx_byte_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= 8'h00;
            nl_q       <= 1'b0;
            idx_q      <= 2'd0;
            col_q      <= 8'd0;
            in_ready_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            nl_q       <= nl_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            in_ready_q <= (state_d == IDLE);
            tx_byte_q  <= tx_byte;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;
    assign dbg_col_o   = col_q;

endmodule

// File: tb/tb_hex_dump_formatter.sv
// Bench for hex_dump_formatter: directed scenarios plus random bytes, with a
// text-level reference model feeding an expected-character queue.
module tb_hex_dump_formatter;

    localparam int BPL = 4;

    logic       clk;
    logic       reset;
    logic [7:0] in_d;
    logic       in_valid;
    logic       in_eof;
    logic       in_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       busy;
    logic [1:0] dbg_state;
    logic [7:0] dbg_col;

    logic       tx_active_m = 1'b0;
    logic       tx_done_m   = 1'b0;
    logic       force_active = 1'b0;
    logic       stray_done   = 1'b0;
    logic       rst_p        = 1'b1;

    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         dv_count = 0;
    int         m_col = 0;

    assign tx_active = tx_active_m | force_active;
    assign tx_done   = tx_done_m | stray_done;

    hex_dump_formatter #(.BYTES_PER_LINE(BPL)) dut (
        .clk(clk), .reset(reset), .in_d(in_d), .in_valid(in_valid),
        .in_eof(in_eof), .in_ready(in_ready), .tx_dv(tx_dv),
        .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
        .busy(busy), .dbg_state_o(dbg_state), .dbg_col_o(dbg_col)
    );

    // ---------------- clock / reset view ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) rst_p <= reset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: text a byte produces, given the current column.
    function automatic void model_push(input logic [7:0] d, input bit eof);
        string hd;
        hd = "0123456789abcdef";
        exp_q.push_back(hd[int'(d[7:4])]);
        exp_q.push_back(hd[int'(d[3:0])]);
        if (eof || m_col == BPL - 1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            m_col = 0;
        end else begin
            exp_q.push_back(8'h20);
            m_col++;
        end
    endfunction

    // ---------------- uart_tx model: tx_done 10 cycles after tx_dv ----------------
    initial begin
        int  cnt;
        logic dv_s;
        cnt = 0;
        forever begin
            @(negedge clk); #1;
            dv_s = tx_dv;
            @(posedge clk); #1;
            tx_done_m = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_active_m = 1'b0;
                    tx_done_m   = 1'b1;
                end
            end
            if (dv_s) begin
                tx_active_m = 1'b1;
                cnt = 10;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [7:0] last;
        last = 8'h00;
        forever begin
            @(negedge clk); #2;
            if (rst_p) begin
                exp_q.delete();
                last = 8'h00;
                check("rst_tx_byte", tx_byte, 8'h00);
                check("rst_tx_dv", tx_dv, 1'b0);
            end else begin
                check("ready_vs_busy", in_ready & busy, 1'b0);
                if (tx_dv) begin
                    dv_count++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_tx_dv", tx_byte, 8'hxx);
                    end else begin
                        check("tx_char", tx_byte, exp_q.pop_front());
                    end
                    last = tx_byte;
                end else begin
                    check("tx_byte_hold", tx_byte, last);
                end
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic drive_byte(input logic [7:0] d, input bit eof, input bit keep);
        int n;
        in_valid = 1'b1;
        in_d     = d;
        in_eof   = eof;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 500, 1'b1);
        if (n < 500) model_push(d, eof);
        @(negedge clk);
        if (!keep) begin
            in_valid = 1'b0;
            in_d     = $urandom_range(0, 255);
            in_eof   = $urandom_range(0, 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); #3;
            n++;
        end while ((busy || exp_q.size() != 0) && n < 3000);
        check("idle_wait", n < 3000, 1'b1);
        @(negedge clk);
    endtask

    task automatic stray_pulse();
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, n;
        reset = 1'b1; in_valid = 1'b0; in_d = 8'h00; in_eof = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_col", dbg_col, 8'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1'b1);

        // Single eof byte, latency of the first strobe
        drive_byte(8'hA5, 1'b1, 1'b0);
        check("lat_load_no_dv", tx_dv, 1'b0);
        @(negedge clk); #1;
        check("lat_hi_dv", tx_dv, 1'b1);
        check("lat_hi_char", tx_byte, 8'h61);
        check("busy_during", busy, 1'b1);
        @(negedge clk);
        wait_idle();
        check("a5_busy_end", busy, 1'b0);
        check("a5_col", dbg_col, 8'd0);

        // Line wrap at BPL and eof on the last byte
        for (int i = 0; i < 4; i++) drive_byte(8'(i), 1'b0, 1'b0);
        drive_byte(8'hFF, 1'b1, 1'b0);
        wait_idle();
        check("wrap_col", dbg_col, 8'd0);

        // uart busy stall at the hi character, with a stray tx_done in SEND
        force_active = 1'b1;
        drive_byte(8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("stall_no_dv", tx_dv, 1'b0);
            if (i == 8) stray_done = 1'b1;
            if (i == 9) stray_done = 1'b0;
            @(negedge clk);
        end
        force_active = 1'b0;
        #1;
        check("stall_release_dv", tx_dv, 1'b1);
        check("stall_release_char", tx_byte, 8'h35);
        @(negedge clk);
        wait_idle();

        // Reset in WAIT after the lo character
        base = dv_count;
        drive_byte(8'h3C, 1'b0, 1'b0);
        n = 0;
        while (dv_count < base + 2 && n < 500) begin
            @(negedge clk); #3;
            n++;
        end
        check("lo_sent_wait", n < 500, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        m_col = 0;
        repeat (2) @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("no_dv_after_rst", dv_count, base + 2);
        check("col_after_rst", dbg_col, 8'd0);
        drive_byte(8'h7E, 1'b1, 1'b0);
        wait_idle();

        // Continuous in_valid with stray tx_done in IDLE
        stray_pulse();
        drive_byte(8'h10, 1'b0, 1'b1);
        drive_byte(8'h20, 1'b0, 1'b0);
        wait_idle();
        check("cont_col", dbg_col, 8'd2);
        check("cont_dv_count", dv_count, base + 2 + 4 + 6);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            if (!busy && $urandom_range(0, 3) == 0) stray_pulse();
            force_active = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            force_active = 1'b0;
            drive_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0), 1'b0);
        end
        wait_idle();
        check("rand_col", dbg_col, 8'(m_col));
        check("rand_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
